second_max_frame_sched: RTL and testbench

//  Round-robin scheduler that shares one running max / second-max tracker

---
 rtl/second_max_frame_sched.sv | 140 ++++++++++++++
 tb/tb_second_max_frame_sched.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/second_max_frame_sched.sv
// Round-robin frame scheduler sharing one running max / second-max tracker.
// Grants one requester per frame (frame ends on the beat with last=1),
// streams that frame through the tracker and returns {max, max2, count, id}
// on a valid/ready result port.
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   req_valid/data/last    per-requester beat stream (requester i data at [i*DATA_WIDTH +: DATA_WIDTH])
//   req_ready              one-hot beat accept, only for the granted requester while streaming
//   res_valid/res_ready    result handshake
//   res_max/max2/count/id  frame statistics and the requester that produced them
module second_max_frame_sched #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned CNT_W      = 16,
   localparam int unsigned ID_W      = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          res_valid,
   input  logic                          res_ready,
   output logic [DATA_WIDTH-1:0]         res_max,
   output logic [DATA_WIDTH-1:0]         res_max2,
   output logic [CNT_W-1:0]              res_count,
   output logic [ID_W-1:0]               res_id
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_RESULT = 2'd2
   } state_t;

   state_t                state, state_n;
   logic [ID_W-1:0]       last_grant;
   logic [ID_W-1:0]       grant_c;
   logic                  found_c;
   logic [DATA_WIDTH-1:0] data_c;
   logic                  last_c;
   logic                  accept_c;

   // Round-robin pick: first valid index at or after last_grant+1 (mod NUM_REQ).
   // Iterating from the farthest offset down lets the nearest one win.
   always_comb begin
      int idx;
      grant_c = '0;
      found_c = 1'b0;
      for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
         idx = (int'(last_grant) + 1 + k) % int'(NUM_REQ);
         if (req_valid[idx]) begin
            found_c = 1'b1;
            grant_c = ID_W'(idx);
         end
      end
   end

   // Beat mux for the granted requester (res_id holds the current grant).
   always_comb begin
      data_c = '0;
      last_c = 1'b0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (res_id == ID_W'(i)) begin
            data_c = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            last_c = req_last[i];
         end
      end
   end

   assign accept_c = (state == ST_STREAM) && (|(req_valid & req_ready));

   // State register.
   always_ff @(posedge clk) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= state_n;
   end

   // Next-state logic.
   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:   if (found_c)                 state_n = ST_STREAM;
         ST_STREAM: if (accept_c && last_c)      state_n = ST_RESULT;
         ST_RESULT: if (res_valid && res_ready)  state_n = ST_IDLE;
         default:                                state_n = ST_IDLE;
      endcase
   end

   // Grant, tracker and result registers; the tracker doubles as res_*.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         last_grant <= ID_W'(NUM_REQ - 1);
         req_ready  <= '0;
         res_valid  <= 1'b0;
         res_max    <= '0;
         res_max2   <= '0;
         res_count  <= '0;
         res_id     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (found_c) begin
                  res_id    <= grant_c;
                  res_max   <= '0;
                  res_max2  <= '0;
                  res_count <= '0;
                  req_ready <= NUM_REQ'(1) << grant_c;
               end
            end
            ST_STREAM: begin
               if (accept_c) begin
                  // Ties fall into max2 so duplicates of the max count separately.
                  if (data_c > res_max) begin
                     res_max2 <= res_max;
                     res_max  <= data_c;
                  end else if (data_c > res_max2) begin
                     res_max2 <= data_c;
                  end
                  if (res_count != {CNT_W{1'b1}}) res_count <= res_count + CNT_W'(1);
                  if (last_c) begin
                     req_ready  <= '0;
                     res_valid  <= 1'b1;
                     last_grant <= res_id;
                  end
               end
            end
            ST_RESULT: begin
               if (res_ready) res_valid <= 1'b0;
            end
            default: begin
               req_ready <= '0;
               res_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_second_max_frame_sched.sv
// Directed bench for second_max_frame_sched with a result scoreboard.
module tb_second_max_frame_sched;

   localparam int unsigned DW = 32;
   localparam int unsigned NR = 4;
   localparam int unsigned CW = 16;

   logic           clk = 1'b0;
   logic           resetn = 1'b0;
   logic [NR-1:0]  req_valid = '0;
   logic [NR*DW-1:0] req_data = '0;
   logic [NR-1:0]  req_last = '0;
   logic [NR-1:0]  req_ready;
   logic           res_valid;
   logic           res_ready = 1'b1;
   logic [DW-1:0]  res_max;
   logic [DW-1:0]  res_max2;
   logic [CW-1:0]  res_count;
   logic [1:0]     res_id;

   typedef struct {
      logic [DW-1:0] mx;
      logic [DW-1:0] mx2;
      logic [CW-1:0] cnt;
      logic [1:0]    id;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;

   second_max_frame_sched #(.DATA_WIDTH(DW), .NUM_REQ(NR), .CNT_W(CW)) dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_max(res_max), .res_max2(res_max2), .res_count(res_count), .res_id(res_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] mx, input logic [DW-1:0] mx2,
                       input logic [CW-1:0] cnt, input logic [1:0] id);
      exp_t e;
      e.mx = mx; e.mx2 = mx2; e.cnt = cnt; e.id = id;
      sb.push_back(e);
   endtask

   // Present one beat on requester r after 'gap' idle cycles and wait for its acceptance.
   task automatic send_beat(input int r, input logic [DW-1:0] d, input logic l, input int gap);
      bit got;
      for (int g = 0; g < gap; g++) tick();
      req_valid[r] = 1'b1;
      req_data[r*DW +: DW] = d;
      req_last[r] = l;
      got = 1'b0;
      for (int c = 0; c < 500 && !got; c++) begin
         @(negedge clk);
         if (req_ready[r]) got = 1'b1;
         tick();
      end
      if (!got) chk("beat_timeout", 64'(r), 64'hFF);
      req_valid[r] = 1'b0;
      req_last[r]  = 1'b0;
   endtask

   // Result monitor: compare each consumed result against the scoreboard head,
   // and check that at most one req_ready bit is ever set.
   always @(negedge clk) begin
      if (resetn) begin
         chk("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
         if (res_valid && res_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_result", 64'(res_id), 64'hEE);
            end else begin
               mon_e = sb.pop_front();
               chk("res_id",    64'(res_id),    64'(mon_e.id));
               chk("res_max",   64'(res_max),   64'(mon_e.mx));
               chk("res_max2",  64'(res_max2),  64'(mon_e.mx2));
               chk("res_count", 64'(res_count), 64'(mon_e.cnt));
            end
         end
      end
   end

   initial begin
      int bidx [NR];
      int frames;
      // Reset values
      tick(); tick();
      @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_res_valid", 64'(res_valid), 64'd0);
      chk("rst_res_max",   64'(res_max),   64'd0);
      chk("rst_res_max2",  64'(res_max2),  64'd0);
      chk("rst_res_count", 64'(res_count), 64'd0);
      chk("rst_res_id",    64'(res_id),    64'd0);
      resetn = 1'b1;
      tick();

      // 1: req0 frame 3,7,5 with one-cycle latency to res_valid
      push(7, 5, 3, 0);
      send_beat(0, 3, 1'b0, 0);
      send_beat(0, 7, 1'b0, 0);
      send_beat(0, 5, 1'b1, 0);
      @(negedge clk);
      chk("t1_latency", 64'(res_valid), 64'd1);
      tick(); tick();

      // 2: tie into max2, then a one-beat frame
      push(9, 9, 2, 2);
      send_beat(2, 9, 1'b0, 0);
      send_beat(2, 9, 1'b1, 0);
      push(4, 0, 1, 1);
      send_beat(1, 4, 1'b1, 0);
      tick(); tick();

      // 4: result back-pressure; a waiting requester must not be granted
      res_ready = 1'b0;
      push(20, 10, 2, 2);
      send_beat(2, 10, 1'b0, 0);
      send_beat(2, 20, 1'b1, 0);
      req_valid[1] = 1'b1;
      req_data[1*DW +: DW] = 32'd6;
      req_last[1] = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("t4_hold_valid", 64'(res_valid), 64'd1);
         chk("t4_hold_max",   64'(res_max),   64'd20);
         chk("t4_hold_max2",  64'(res_max2),  64'd10);
         chk("t4_hold_ready", 64'(req_ready), 64'd0);
         tick();
      end
      res_ready = 1'b1;
      push(6, 0, 1, 1);
      send_beat(1, 6, 1'b1, 0);
      tick(); tick();

      // 6: gaps between beats do not disturb the tracker
      push(8, 8, 4, 1);
      send_beat(1, 1, 1'b0, 3);
      send_beat(1, 8, 1'b0, 3);
      send_beat(1, 2, 1'b0, 3);
      send_beat(1, 8, 1'b1, 3);
      tick(); tick();

      // 5: reset mid-frame discards the frame; pointer returns to requester 0
      send_beat(3, 100, 1'b0, 0);
      send_beat(3, 90, 1'b0, 0);
      resetn = 1'b0;
      tick(); tick();
      @(negedge clk);
      chk("t5_rst_valid", 64'(res_valid), 64'd0);
      chk("t5_rst_ready", 64'(req_ready), 64'd0);
      resetn = 1'b1;
      req_valid[3] = 1'b1;
      req_data[3*DW +: DW] = 32'd50;
      req_last[3] = 1'b1;
      push(2, 1, 2, 0);
      push(50, 0, 1, 3);
      send_beat(0, 1, 1'b0, 0);
      send_beat(0, 2, 1'b1, 0);
      send_beat(3, 50, 1'b1, 0);
      tick(); tick();

      // 3: all requesters continuously valid, 2-beat frames -> ids 0,1,2,3,0
      for (int r = 0; r < int'(NR); r++) begin
         bidx[r] = 0;
         req_data[r*DW +: DW] = 32'(r*16 + 1);
         req_last[r] = 1'b0;
      end
      for (int f = 0; f < 5; f++)
         push(32'((f % 4)*16 + 2), 32'((f % 4)*16 + 1), 2, 2'(f % 4));
      req_valid = '1;
      frames = 0;
      for (int c = 0; c < 500 && frames < 5; c++) begin
         int acc;
         @(negedge clk);
         acc = -1;
         for (int r = 0; r < int'(NR); r++) if (req_ready[r]) acc = r;
         tick();
         if (acc >= 0) begin
            if (bidx[acc] == 1) begin
               frames++;
               bidx[acc] = 0;
            end else begin
               bidx[acc] = 1;
            end
            req_data[acc*DW +: DW] = 32'(acc*16 + bidx[acc] + 1);
            req_last[acc] = (bidx[acc] == 1);
         end
      end
      req_valid = '0;
      req_last  = '0;
      chk("t3_frames", 64'(frames), 64'd5);

      // Drain the scoreboard
      for (int c = 0; c < 100 && sb.size() != 0; c++) tick();
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
